fetch_ctrl: RTL and testbench

Instruction-fetch controller that consumes the stall requests produced by `stallingUnit` and applies them to the front of the pipeline. It owns the program counter, drives the instruction-memory address, and writes the IF/ID pipeline register, inserting NOP bubbles or holding the PC on request. It also accepts branch/jump redirects from the execute stage and runs the halt-drain sequence.

---
 rtl/fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives imem_addr, writes the IF/ID
// register with bubbles/holds on request, handles EX redirects and halt-drain.
module fetch_ctrl #(
    parameter int unsigned         XLEN         = 32,
    parameter logic [XLEN-1:0]     RESET_PC     = '0,
    parameter logic [31:0]         NOP_INSTR    = 32'h0000_0013,
    parameter int unsigned         DRAIN_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_en,
    input  logic            pc_hold,
    input  logic            halt_req,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] imem_addr,
    output logic            ifid_valid,
    output logic [31:0]     ifid_instr,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic            halted,
    output logic [31:0]     cnt_cycles,
    output logic [31:0]     cnt_bubbles,
    output logic [31:0]     cnt_redirects
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redir_tgt;
    logic [3:0]      r_drain_cnt;
    logic [3:0]      w_drain_cnt_nxt;
    logic            w_ifid_wr;
    logic            w_bubble;
    logic            w_redir_acc;

    logic            r_ifid_valid;
    logic [31:0]     r_ifid_instr;
    logic [XLEN-1:0] r_ifid_pc;
    logic [XLEN-1:0] r_ifid_pc_plus4;
    logic [31:0]     r_cnt_cycles;
    logic [31:0]     r_cnt_bubbles;
    logic [31:0]     r_cnt_redirects;

    assign w_pc_plus4  = r_pc + XLEN'(4);
    assign w_redir_tgt = redirect_pc & ~XLEN'(3);

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_drain_cnt_nxt = r_drain_cnt;
        w_ifid_wr       = 1'b0;
        w_bubble        = 1'b0;
        w_redir_acc     = 1'b0;
        case (r_state)
            S_RUN: begin
                w_ifid_wr = 1'b1;
                // Halt wins over a same-cycle redirect; the redirect is dropped.
                if (halt_req) begin
                    w_state_nxt     = S_DRAIN;
                    w_drain_cnt_nxt = DRAIN_LOAD;
                    w_bubble        = 1'b1;
                end else begin
                    w_bubble = redirect_valid | stall_en;
                    if (redirect_valid) begin
                        w_pc_nxt    = w_redir_tgt;
                        w_redir_acc = 1'b1;
                    end else if (!pc_hold) begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
            end
            S_DRAIN: begin
                w_ifid_wr = 1'b1;
                w_bubble  = 1'b1;
                if (r_drain_cnt == 4'd0) begin
                    w_state_nxt = S_HALTED;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - 4'd1;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_RUN;
            r_pc            <= RESET_PC;
            r_drain_cnt     <= '0;
            r_ifid_valid    <= 1'b0;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc       <= '0;
            r_ifid_pc_plus4 <= '0;
            r_cnt_cycles    <= '0;
            r_cnt_bubbles   <= '0;
            r_cnt_redirects <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            if (w_ifid_wr) begin
                r_ifid_valid    <= ~w_bubble;
                r_ifid_instr    <= w_bubble ? NOP_INSTR : imem_rdata;
                r_ifid_pc       <= r_pc;
                r_ifid_pc_plus4 <= w_pc_plus4;
            end
            if (r_state != S_HALTED && r_cnt_cycles != '1) begin
                r_cnt_cycles <= r_cnt_cycles + 32'd1;
            end
            if (w_bubble && r_cnt_bubbles != '1) begin
                r_cnt_bubbles <= r_cnt_bubbles + 32'd1;
            end
            if (w_redir_acc && r_cnt_redirects != '1) begin
                r_cnt_redirects <= r_cnt_redirects + 32'd1;
            end
        end
    end

    assign imem_addr     = r_pc;
    assign ifid_valid    = r_ifid_valid;
    assign ifid_instr    = r_ifid_instr;
    assign ifid_pc       = r_ifid_pc;
    assign ifid_pc_plus4 = r_ifid_pc_plus4;
    assign halted        = (r_state == S_HALTED);
    assign cnt_cycles    = r_cnt_cycles;
    assign cnt_bubbles   = r_cnt_bubbles;
    assign cnt_redirects = r_cnt_redirects;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected IF/ID contents and next PC are queued
// when each step is driven and compared one cycle later.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall_en;
    logic        pc_hold;
    logic        halt_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        halted;
    logic [31:0] cnt_cycles;
    logic [31:0] cnt_bubbles;
    logic [31:0] cnt_redirects;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] nxt;
    } exp_t;

    exp_t sb[$];

    fetch_ctrl #(
        .XLEN(32),
        .RESET_PC(32'h0),
        .NOP_INSTR(NOP),
        .DRAIN_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall_en(stall_en),
        .pc_hold(pc_hold),
        .halt_req(halt_req),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_rdata(imem_rdata),
        .imem_addr(imem_addr),
        .ifid_valid(ifid_valid),
        .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc),
        .ifid_pc_plus4(ifid_pc_plus4),
        .halted(halted),
        .cnt_cycles(cnt_cycles),
        .cnt_bubbles(cnt_bubbles),
        .cnt_redirects(cnt_redirects)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign imem_rdata = mem(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic st, input logic hd, input logic hl, input logic rv,
                        input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                        input logic [31:0] enxt);
        exp_t e;
        stall_en       = st;
        pc_hold        = hd;
        halt_req       = hl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        e.v     = ev;
        e.instr = ev ? mem(epc) : NOP;
        e.pc    = epc;
        e.pc4   = epc + 32'd4;
        e.nxt   = enxt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.v});
            chk("ifid_instr", ifid_instr, e.instr);
            chk("ifid_pc", ifid_pc, e.pc);
            chk("ifid_pc_plus4", ifid_pc_plus4, e.pc4);
            chk("imem_addr", imem_addr, e.nxt);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_ifid_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_ifid_instr", ifid_instr, NOP);
        chk("rst_ifid_pc", ifid_pc, 32'h0);
        chk("rst_ifid_pc_plus4", ifid_pc_plus4, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_cnt_cycles", cnt_cycles, 32'd0);
        chk("rst_cnt_bubbles", cnt_bubbles, 32'd0);
        chk("rst_cnt_redirects", cnt_redirects, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        stall_en = 1'b0;
        pc_hold = 1'b0;
        halt_req = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        #2;
        chk_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // sequential fetch
        step(0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h4);
        step(0, 0, 0, 0, 32'h0, 1, 32'h4, 32'h8);
        step(0, 0, 0, 0, 32'h0, 1, 32'h8, 32'hC);
        step(0, 0, 0, 0, 32'h0, 1, 32'hC, 32'h10);
        chk("seq_bubbles", cnt_bubbles, 32'd0);
        chk("seq_cycles", cnt_cycles, 32'd4);

        // branch shadow: redirect + 3 stall cycles, 2 of them holding the PC
        step(1, 0, 0, 1, 32'h40, 0, 32'h10, 32'h40);
        step(1, 1, 0, 0, 32'h0, 0, 32'h40, 32'h40);
        step(1, 1, 0, 0, 32'h0, 0, 32'h40, 32'h40);
        step(0, 0, 0, 0, 32'h0, 1, 32'h40, 32'h44);
        chk("br_redirects", cnt_redirects, 32'd1);
        chk("br_bubbles", cnt_bubbles, 32'd3);
        chk("br_cycles", cnt_cycles, 32'd8);

        // load-use at 0x10 (reached via a misaligned redirect to 0x13)
        step(0, 0, 0, 1, 32'h13, 0, 32'h44, 32'h10);
        step(1, 1, 0, 0, 32'h0, 0, 32'h10, 32'h10);
        step(0, 0, 0, 0, 32'h0, 1, 32'h10, 32'h14);
        step(0, 0, 0, 0, 32'h0, 1, 32'h14, 32'h18);

        // misaligned redirect, hold-only replay, redirect beats hold, PC wrap
        step(0, 0, 0, 1, 32'h23, 0, 32'h18, 32'h20);
        step(0, 0, 0, 0, 32'h0, 1, 32'h20, 32'h24);
        step(0, 1, 0, 0, 32'h0, 1, 32'h24, 32'h24);
        step(0, 0, 0, 0, 32'h0, 1, 32'h24, 32'h28);
        step(0, 1, 0, 1, 32'hFFFF_FFFF, 0, 32'h28, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h0);
        step(0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h4);
        chk("mid_redirects", cnt_redirects, 32'd4);
        chk("mid_bubbles", cnt_bubbles, 32'd7);

        // stall without hold squashes and still advances
        step(1, 0, 0, 0, 32'h0, 0, 32'h4, 32'h8);
        step(0, 0, 0, 0, 32'h0, 1, 32'h8, 32'hC);
        chk("sq_bubbles", cnt_bubbles, 32'd8);
        chk("sq_cycles", cnt_cycles, 32'd21);

        // halt with simultaneous redirect, then drain with noisy inputs
        step(0, 0, 1, 1, 32'h80, 0, 32'hC, 32'hC);
        chk("halt_n", {31'b0, halted}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 1, 32'h200, 0, 32'hC, 32'hC);
            chk("halt_rise", {31'b0, halted}, (i == 3) ? 32'd1 : 32'd0);
        end
        chk("halt_redirects", cnt_redirects, 32'd4);
        chk("halt_cycles", cnt_cycles, 32'd26);
        chk("halt_bubbles", cnt_bubbles, 32'd13);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 1, 32'h300, 0, 32'hC, 32'hC);
        end
        chk("frz_halted", {31'b0, halted}, 32'd1);
        chk("frz_cycles", cnt_cycles, 32'd26);
        chk("frz_bubbles", cnt_bubbles, 32'd13);
        chk("frz_redirects", cnt_redirects, 32'd4);

        // reset mid-drain
        rst = 1'b1;
        #1;
        chk_reset_vals();
        #3;
        rst = 1'b0;
        step(0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h4);
        step(0, 0, 1, 0, 32'h0, 0, 32'h4, 32'h4);
        step(0, 0, 0, 0, 32'h0, 0, 32'h4, 32'h4);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals();
        #3;
        rst = 1'b0;
        step(0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h4);
        step(0, 0, 0, 0, 32'h0, 1, 32'h4, 32'h8);
        chk("post_rst_cycles", cnt_cycles, 32'd2);
        chk("post_rst_halted", {31'b0, halted}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
